// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and default widths for the memory port arbiter
package rv32i_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;
  localparam int AW_DEFAULT = 32;
  localparam int DW_DEFAULT = 32;
endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: saturating access timer with clear and enable, expires on the last allowed cycle
module mem_arb_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [TW-1:0] tcnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) tcnt <= '0;
    else if (clr) tcnt <= '0;
    else if (en && tcnt != TMAX) tcnt <= tcnt + 1'b1;
  assign expire = TIMEOUT_CYCLES != 0 && tcnt == TLAST;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one req/ack bus with data priority and timeout
module mem_port_arbiter import rv32i_pkg::*; #(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [DW/8-1:0] dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [DW/8-1:0] bus_be,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic [DW-1:0] bus_rdata,
  input  logic          bus_ack,
  output logic          busy
);
  localparam int SW = $clog2(MAX_DATA_BURST + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_BURST);
  arb_state_t state_q, state_d;
  arb_owner_t owner;
  logic [SW-1:0] streak;
  logic err_q, expire, grant_if, start, finish;
  always_comb begin
    grant_if = if_req && (!dm_req || streak == SMAX);
    start = state_q == IDLE && (if_req || dm_req);
    finish = state_q == ACCESS && (bus_ack || expire);
    state_d = start ? ACCESS : finish ? DONE : state_q == DONE ? IDLE : state_q;
  end
  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .reset(reset), .clr(state_q != ACCESS),
    .en(state_q == ACCESS && !bus_ack), .expire(expire)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner <= OWN_IF;
      streak <= '0;
      err_q <= 1'b0;
      bus_we <= 1'b0;
      bus_be <= '0;
      bus_addr <= '0;
      bus_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if (start) begin
        owner <= grant_if ? OWN_IF : OWN_DM;
        streak <= (grant_if || !if_req) ? '0 : streak + SW'(streak != SMAX);
        bus_we <= grant_if ? 1'b0 : dm_we;
        bus_be <= grant_if ? '1 : dm_be;
        bus_addr <= grant_if ? if_addr : dm_addr;
        bus_wdata <= grant_if ? bus_wdata : dm_wdata;
      end
      // ack beats a same-cycle timeout; acked stores keep the previous load data
      if (finish) begin
        err_q <= !bus_ack;
        if (owner == OWN_IF) if_rdata <= bus_ack ? bus_rdata : '0;
        else if (!bus_we || !bus_ack) dm_rdata <= bus_ack ? bus_rdata : '0;
      end
    end
  end
  assign bus_req = state_q == ACCESS;
  assign busy = state_q != IDLE;
  assign if_done = state_q == DONE && owner == OWN_IF;
  assign dm_done = state_q == DONE && owner == OWN_DM;
  assign if_err = if_done && err_q;
  assign dm_err = dm_done && err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with a behavioural bus responder and random two-port traffic
module tb_mem_port_arbiter;
  logic clk = 0, reset;
  logic if_req, if_done, if_err, dm_req, dm_we, dm_done, dm_err;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [3:0] dm_be, bus_be;
  logic bus_req, bus_we, bus_ack, busy;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = 0;
  logic resp_ack = 0, late_ack = 0;
  int checks = 0, errors = 0;
  int fixed_lat = 0, last_run = 0, run = 0, lat_k = 0;
  logic [68:0] attr0;
  logic [31:0] exp_dm_rdata = 0;
  typedef struct {
    logic [31:0] rdata;
    logic err;
    logic [31:0] addr;
    logic we;
    logic [3:0] be;
    logic [31:0] wdata;
    logic chk_wd;
  } exp_t;
  exp_t if_q[$], dm_q[$];
  exp_t mi, md;
  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(8), .MAX_DATA_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_err(dm_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .busy(busy)
  );
  always #5 clk = ~clk;
  assign bus_ack = resp_ack | late_ack;
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEADBFEF;
  endfunction
  function automatic logic hang(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction
  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic do_dm(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat);
    exp_t e;
    e.err = hang(addr);
    e.rdata = e.err ? 32'h0 : we ? exp_dm_rdata : mem_data(addr);
    exp_dm_rdata = e.rdata;
    e.addr = addr; e.we = we; e.be = be; e.wdata = wd; e.chk_wd = 1'b1;
    dm_q.push_back(e);
    dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wd; dm_req = 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dm_done && lat < 200);
    if (!dm_done) begin
      checks++; errors++;
      $display("FAIL dm_wait got no done want done");
    end
    dm_req = 0;
  endtask
  task automatic do_if(input logic [31:0] addr, output int lat);
    exp_t e;
    e.err = hang(addr);
    e.rdata = e.err ? 32'h0 : mem_data(addr);
    e.addr = addr; e.we = 1'b0; e.be = 4'hF; e.wdata = 32'h0; e.chk_wd = 1'b0;
    if_q.push_back(e);
    if_addr = addr; if_req = 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if_done && lat < 200);
    if (!if_done) begin
      checks++; errors++;
      $display("FAIL if_wait got no done want done");
    end
    if_req = 0;
  endtask
  // bus responder: acks after a chosen latency, never acks hang addresses, checks attribute stability
  initial forever begin
    @(negedge clk);
    resp_ack = 0;
    bus_rdata = $urandom;
    if (bus_req) begin
      if (run == 0) begin
        attr0 = {bus_we, bus_be, bus_addr, bus_wdata};
        lat_k = hang(bus_addr) ? 1000000 : fixed_lat >= 0 ? fixed_lat : int'($urandom_range(0, 3));
      end else chk("bus_attr_stable", {bus_we, bus_be, bus_addr, bus_wdata}, attr0);
      if (run == lat_k) begin
        resp_ack = 1;
        bus_rdata = mem_data(bus_addr);
      end
      run++;
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end
  always @(negedge clk) if (reset) begin
    if (if_done && dm_done) begin
      checks++; errors++;
      $display("FAIL both_done got 11 want one");
    end
    if (if_done) begin
      if (if_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_spurious_done got done want none");
      end else begin
        mi = if_q.pop_front();
        chk("if_rdata", if_rdata, mi.rdata);
        chk("if_err", if_err, mi.err);
        chk("if_bus_addr", bus_addr, mi.addr);
        chk("if_bus_we_be", {bus_we, bus_be}, {1'b0, 4'hF});
      end
    end
    if (dm_done) begin
      if (dm_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dm_spurious_done got done want none");
      end else begin
        md = dm_q.pop_front();
        chk("dm_rdata", dm_rdata, md.rdata);
        chk("dm_err", dm_err, md.err);
        chk("dm_bus_addr", bus_addr, md.addr);
        chk("dm_bus_we_be", {bus_we, bus_be}, {md.we, md.be});
        if (md.chk_wd) chk("dm_bus_wdata", bus_wdata, md.wdata);
      end
    end
  end
  initial begin
    int lat, lat_if, lat_dm, n;
    exp_t e;
    reset = 0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {bus_req, busy, if_done, dm_done, if_err, dm_err, bus_we, bus_be}, 0);
    chk("rst_bus_addr_wdata", {bus_addr, bus_wdata}, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    reset = 1;
    @(negedge clk);
    fixed_lat = 2;
    do_dm(1'b0, 4'hF, 32'h100, 32'h0, lat);
    chk("load_latency", lat, 4);
    @(negedge clk);
    fixed_lat = 0;
    do_if(32'h0, lat);
    chk("zero_ack_latency", lat, 2);
    @(negedge clk);
    fixed_lat = 1;
    do_dm(1'b1, 4'h3, 32'h200, 32'h1234, lat);
    chk("store_latency", lat, 3);
    @(negedge clk);
    do_dm(1'b0, 4'hF, 32'hF000_0100, 32'h0, lat);
    chk("timeout_latency", lat, 9);
    repeat (2) @(negedge clk);
    chk("timeout_req_cycles", last_run, 8);
    late_ack = 1;
    @(negedge clk);
    late_ack = 0;
    repeat (3) @(negedge clk);
    chk("late_ack_ignored", {busy, dm_rdata}, 0);
    // contention: four data grants, then one fetch, repeating
    fixed_lat = 1;
    e.err = 0; e.we = 0; e.be = 4'hF; e.chk_wd = 0; e.wdata = 0;
    e.addr = 32'h400; e.rdata = mem_data(32'h400);
    for (int i = 0; i < 5; i++) if_q.push_back(e);
    e.addr = 32'h1000_0400; e.rdata = mem_data(32'h1000_0400); e.wdata = 32'h55; e.chk_wd = 1;
    for (int i = 0; i < 20; i++) dm_q.push_back(e);
    exp_dm_rdata = e.rdata;
    if_addr = 32'h400; dm_we = 0; dm_be = 4'hF; dm_addr = 32'h1000_0400; dm_wdata = 32'h55;
    if_req = 1; dm_req = 1;
    n = 0;
    for (int c = 0; c < 1000 && n < 25; c++) begin
      @(negedge clk);
      if (if_done || dm_done) begin
        chk("grant_order", if_done, n % 5 == 4);
        n++;
      end
    end
    if_req = 0; dm_req = 0;
    if (n < 25) begin
      checks++; errors++;
      $display("FAIL contention_grants got %0d want 25", n);
    end
    @(negedge clk);
    fixed_lat = -1;
    fork
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_if(($urandom_range(0, 9) == 0 ? 32'hF000_0000 : 32'h0) | ($urandom & 32'h0FFF_FFFC), lat_if);
      end
      for (int i = 0; i < 15; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_dm(1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
              ($urandom_range(0, 9) == 0 ? 32'hF000_0000 : 32'h1000_0000) | ($urandom & 32'h0FFF_FFFC),
              $urandom, lat_dm);
      end
    join
    @(negedge clk);
    dm_we = 0; dm_be = 4'hF; dm_addr = 32'hF000_0040; dm_req = 1;
    repeat (3) @(negedge clk);
    chk("pre_reset_active", {bus_req, busy}, 2'b11);
    #2 reset = 0;
    #1 chk("reset_drop", {bus_req, busy}, 0);
    dm_req = 0;
    @(negedge clk);
    reset = 1;
    exp_dm_rdata = 0;
    repeat (5) @(negedge clk);
    chk("post_reset_quiet", {busy, dm_done, if_done, dm_rdata}, 0);
    fixed_lat = 1;
    do_dm(1'b0, 4'hF, 32'h1000_0040, 32'h0, lat);
    chk("post_reset_latency", lat, 3);
    repeat (2) @(negedge clk);
    chk("queues_drained", if_q.size() + dm_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single shared memory/IO port toward the ESP32 link. It serialises instruction fetches from the fetch stage and loads/stores from the memory stage onto one request/acknowledge bus. Data accesses have priority, with bounded starvation of fetch, and a hung bus is reported through a per-access timeout. It sits between the pipeline stages and the external bus, inside the CPU top level.

## Interface
- AW, 32, address width
- DW, 32, data width (byte strobes DW/8)
- TIMEOUT_CYCLES, 255, bus cycles without ack before abort; 0 disables timeout
- MAX_DATA_BURST, 4, consecutive data grants allowed while fetch is waiting (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held, with if_addr stable, until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word, valid while if_done=1
- if_done  out  1  one-cycle completion pulse
- if_err  out  1  qualifies if_done: access timed out
- dm_req  in  1  data request; held, with attributes stable, until dm_done
- dm_we  in  1  1=store, 0=load
- dm_be  in  DW/8  byte enables
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data, valid while dm_done=1 and dm_we=0
- dm_done  out  1  one-cycle completion pulse
- dm_err  out  1  qualifies dm_done: access timed out
- bus_req  out  1  bus request; held with attributes until bus_ack or timeout
- bus_we, bus_be, bus_addr, bus_wdata  out  1/DW/8/AW/DW  registered bus attributes
- bus_rdata  in  DW  read data, sampled with bus_ack
- bus_ack  in  1  one-cycle completion from bus; may arrive in the first bus_req cycle
- busy  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Neither request pending: stay in IDLE.
  - Otherwise grant one requester, latch owner and attributes into the bus_* registers, go to ACCESS.
  - Fetch grants drive bus_we=0, bus_be=all ones, bus_wdata unchanged.
- Arbitration:
  - Grant fetch if only if_req is high, or if both are high and streak=MAX_DATA_BURST.
  - Otherwise grant data.
- Streak counter:
  - On a data grant with if_req=1: +1, saturating at MAX_DATA_BURST.
  - Cleared on any fetch grant, and on a data grant with if_req=0.
- ACCESS:
  - bus_req=1.
  - On bus_ack: capture bus_rdata into the owner's rdata register (reads only; stores leave dm_rdata unchanged), err=0, go to DONE.
  - Otherwise tcnt+1.
  - When tcnt=TIMEOUT_CYCLES−1 and no ack: owner rdata←0, err=1, go to DONE.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - Owner's done=1 and err as recorded; go to IDLE.
  - Requests are next sampled in IDLE, so a requester drops req on the edge where it sees done, or keeps it high to issue a new access.
- bus_ack outside ACCESS is ignored: no state change, no capture.
- tcnt is cleared on entry to ACCESS and is ⌈log2(TIMEOUT_CYCLES+1)⌉ bits wide.
- Reset (asynchronous, any state): IDLE; streak=0, tcnt=0; all outputs 0, including bus_* attributes and rdata. An in-flight bus access is abandoned with no done.

## Timing
- Request seen in IDLE at cycle 0:
  - bus_req=1 from cycle 1.
  - bus_ack at cycle 1+k (k≥0).
  - done pulse at cycle 2+k.
  - IDLE again at cycle 3+k.
- Minimum 3 cycles per access.
- Timeout: bus_req high for exactly TIMEOUT_CYCLES cycles, then done+err in the next cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- bus_* attributes stay constant from the first bus_req cycle until the cycle after ack or timeout, and hold their last value in IDLE and DONE.
- Fetch and data done are never asserted in the same cycle.

## Structure
- Shared package rv32i_pkg holds:
  - arb_state_t enum {IDLE, ACCESS, DONE}
  - arb_owner_t enum {OWN_IF, OWN_DM}
  - default AW/DW constants
- One natural sub-module, mem_arb_timer: loadable saturating counter with clear, enable and expire output, parameterised by TIMEOUT_CYCLES. TIMEOUT_CYCLES=0 ties expire low.
- FSM, arbitration and streak counter live in the top module.

## Test plan
- Single load: dm_req, dm_we=0, addr 0x100; bus acks 2 cycles after bus_req with 0xDEADBEEF → dm_done at cycle 4, dm_rdata=0xDEADBEEF, dm_err=0.
- Zero-latency ack: if_req addr 0x0, ack in the first bus_req cycle → if_done at cycle 2, bus_be=0xF, bus_we=0.
- Contention: both requests held continuously, MAX_DATA_BURST=4 → grant order DM,DM,DM,DM,IF,DM,…; no two consecutive IF grants while dm_req is high.
- Timeout: TIMEOUT_CYCLES=8, no ack → bus_req high exactly 8 cycles, dm_done=1 with dm_err=1 and dm_rdata=0. A late ack 3 cycles later is ignored.
- Store: dm_we=1, be=0x3, wdata 0x1234 → bus attributes match and stay stable until ack; dm_rdata keeps its previous value.
- Reset mid-ACCESS: assert reset between clock edges → bus_req and busy drop immediately; after release, no done pulse, and a fresh request completes normally.
